pif_xbus_arb: RTL and testbench
===============================

Name: pif_xbus_arb

Overview:
- Two-requester arbiter and sequencer for the PIF register bus: XI write strobe, address, sub-address, data and the XO readback.
- Requesters are, for example, the I2C slave front end and an internal maintenance master. The block grants one requester at a time and generates the XI strobes.
- Reads are held for the register file's fixed pipeline latency, then XO is captured and returned to the owning requester.

Parameters:
- AW, 8: XI address width; matches the XI_PRWA width.
- SUBW, 4: XI read sub-address width.
- DW, 8: data width for both XI write data and XO.
- RD_LAT, 5: cycles from XI address valid to XO valid. Legal range is 1..15.

Ports:
- xclk  in  1  clock
- sys_rst  in  1  reset; asynchronous, active-low
- r0_req, r1_req  in  1 each  request; hold until matching rN_done
- r0_we, r1_we  in  1 each  1 = write, 0 = read
- r0_addr, r1_addr  in  AW each  register address
- r0_suba, r1_suba  in  SUBW each  read sub-address
- r0_wdata, r1_wdata  in  DW each  write data
- r0_gnt, r1_gnt  out  1 each  one-cycle pulse: request accepted
- r0_done, r1_done  out  1 each  one-cycle pulse: transaction complete
- r0_rdata, r1_rdata  out  DW each  read result; valid from done until that requester's next read completes
- xi_pwr  out  1  single-cycle write strobe
- xi_prwa  out  AW  register address
- xi_prdsuba  out  SUBW  read sub-address
- xi_pd  out  DW  write data
- xi_prdfinished  out  1  one-cycle pulse when read data is captured
- xo  in  DW  register-file readback
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset: every output is 0. State is IDLE, the wait counter is 0, and last_gnt = 1, so r0 wins the first contention.
- Reset mid-transaction: the transaction is abandoned, no done pulse is issued, and the requester must re-request.
- States: IDLE, WR, RD_WAIT, CAPT, DONE.
- IDLE: if any req is high, choose the owner.
  - One request pending: that requester is granted.
  - Both pending: grant the requester that is not last_gnt.
  - On grant: latch the owner's we/addr/suba/wdata into xi_* registers, pulse rN_gnt in the next cycle (C1), update last_gnt.
  - Go to WR if we=1, otherwise RD_WAIT.
- WR (C1):
  - xi_pwr = 1 for exactly this cycle; xi_prwa and xi_pd are valid.
  - Next state DONE, so done arrives in C2.
- RD_WAIT:
  - xi_prwa and xi_prdsuba are held constant.
  - The counter runs from 1 up to RD_LAT, starting in C1.
  - When the counter equals RD_LAT, go to CAPT.
- CAPT (C1+RD_LAT):
  - Register xo into the owner's rdata.
  - Pulse xi_prdfinished.
  - Next state DONE.
- DONE:
  - Pulse the owner's rN_done for one cycle; rdata is valid in this cycle.
  - Return to IDLE.
  - Write done is in C2; read done is in C(RD_LAT+2), which is cycle 7 at the default RD_LAT = 5.
- Idle bus: xi_prwa, xi_prdsuba and xi_pd hold their last values; xi_pwr is 0.
- Request sampling:
  - req is sampled only in IDLE.
  - A requester that keeps req high in the cycle after done starts a new transaction.
  - Changing request fields while granted has no effect; the fields were latched at grant.
- Back-to-back: the minimum gap between transactions is one IDLE cycle.
- Fairness: with both requesters continuously requesting, grants alternate r0, r1, r0, …
- Ordering: gnt always precedes done for the same requester. Both done outputs are never high together.

Optional Feature:
- Macro PIF_ARB_FIXED_PRIO_EN.
- Defined: r0 always wins contention and last_gnt is ignored; r1 can starve.
- Undefined: round-robin as specified under Behaviour.

Decomposition:
- Add to the shared defines file:
  - state encodings: PIF_ARB_IDLE, PIF_ARB_WR, PIF_ARB_RD_WAIT, PIF_ARB_CAPT, PIF_ARB_DONE
  - default read latency: PIF_XI_RD_LAT = 5
- One natural sub-module: pif_rr_arb2.
  - Combinational two-way grant select plus the registered last_gnt pointer.
  - Also contains the PIF_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Write: r0 writes addr 0x02, wdata 0x55 → xi_pwr high only in C1 with xi_prwa 0x02 and xi_pd 0x55; r0_done in C2; busy for 2 cycles.
- Read (RD_LAT = 5): r1 reads addr 0x00, suba 0x3; model drives xo = 0x63 at C6 → xi_prdfinished at C6; r1_done at C7 with r1_rdata 0x63; xi_prwa held 0x00 throughout C1–C6.
- Contention: both req in the same cycle after reset → r0 granted first, then r1. Repeat with continuous requests → alternating grants.
- With PIF_ARB_FIXED_PRIO_EN defined: r0 and r1 continuously requesting → r0 granted every transaction; r1_gnt never asserts.
- Reset mid-read: assert sys_rst at C3 of a read → all outputs 0 immediately and no done. After release, a re-issued read completes normally at RD_LAT+2.
- Hold req after done: r0 keeps req high → a second transaction's gnt one cycle after done; r0_rdata is unchanged until the second read's done.

Source files
------------

// File: rtl/pif_xbus_arb_pkg.sv
// pif_xbus_arb_pkg
// Shared definitions for the PIF XI bus arbiter: sequencer state encodings,
// the default register-file read latency and the wait-counter width.
// Optional build macro used by this slice: PIF_ARB_FIXED_PRIO_EN (see pif_rr_arb2).
package pif_xbus_arb_pkg;

  typedef enum logic [2:0] {
    PIF_ARB_IDLE    = 3'd0,
    PIF_ARB_WR      = 3'd1,
    PIF_ARB_RD_WAIT = 3'd2,
    PIF_ARB_CAPT    = 3'd3,
    PIF_ARB_DONE    = 3'd4
  } pif_arb_state_e;

  // Register-file pipeline latency from XI address valid to XO valid.
  localparam int unsigned PIF_XI_RD_LAT = 5;

  // Wait counter width; covers the legal RD_LAT range 1..15.
  localparam int unsigned PIF_ARB_CNT_W = 4;

endpackage

// File: rtl/pif_rr_arb2.sv
// pif_rr_arb2
// Two-way grant select with a registered last-grant pointer.
//   xclk      : clock
//   sys_rst   : asynchronous active-low reset (pointer resets to 1 so r0 wins first)
//   i_req0/1  : requests
//   i_take    : the selection is accepted this cycle; pointer updates
//   o_sel     : selected requester (0 = r0, 1 = r1), valid when any request is high
// Build macro PIF_ARB_FIXED_PRIO_EN: r0 always wins contention, pointer ignored.
module pif_rr_arb2 (
  input  logic xclk,
  input  logic sys_rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_sel
);

  logic r_last_gnt;

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_last_gnt <= 1'b1;
    end else if (i_take) begin
      r_last_gnt <= o_sel;
    end
  end

  always_comb begin
    o_sel = 1'b0;
    if (i_req1 && !i_req0) begin
      o_sel = 1'b1;
    end else if (i_req0 && i_req1) begin
`ifdef PIF_ARB_FIXED_PRIO_EN
      o_sel = 1'b0;
`else
      // Contention: whoever was not granted last time wins.
      o_sel = ~r_last_gnt;
`endif
    end
  end

endmodule

// File: rtl/pif_xbus_arb.sv
// pif_xbus_arb
// Two-requester arbiter and sequencer for the PIF XI register bus.
// Grants one requester at a time, latches its command into the XI registers,
// issues a one-cycle write strobe or waits RD_LAT cycles for XO, captures the
// readback into the owner's rdata and pulses the owner's done.
// Ports:
//   xclk, sys_rst (async active-low)
//   rN_req/we/addr/suba/wdata : requester N command (held until rN_done)
//   rN_gnt, rN_done           : one-cycle accept / complete pulses
//   rN_rdata                  : last read result for requester N
//   xi_pwr, xi_prwa, xi_prdsuba, xi_pd, xi_prdfinished : XI bus outputs
//   xo                        : register-file readback
//   busy                      : sequencer not idle
// Build macro PIF_ARB_FIXED_PRIO_EN (in pif_rr_arb2): fixed r0 priority.
module pif_xbus_arb
  import pif_xbus_arb_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned SUBW   = 4,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = PIF_XI_RD_LAT
) (
  input  logic            xclk,
  input  logic            sys_rst,
  input  logic            r0_req,
  input  logic            r1_req,
  input  logic            r0_we,
  input  logic            r1_we,
  input  logic [AW-1:0]   r0_addr,
  input  logic [AW-1:0]   r1_addr,
  input  logic [SUBW-1:0] r0_suba,
  input  logic [SUBW-1:0] r1_suba,
  input  logic [DW-1:0]   r0_wdata,
  input  logic [DW-1:0]   r1_wdata,
  output logic            r0_gnt,
  output logic            r1_gnt,
  output logic            r0_done,
  output logic            r1_done,
  output logic [DW-1:0]   r0_rdata,
  output logic [DW-1:0]   r1_rdata,
  output logic            xi_pwr,
  output logic [AW-1:0]   xi_prwa,
  output logic [SUBW-1:0] xi_prdsuba,
  output logic [DW-1:0]   xi_pd,
  output logic            xi_prdfinished,
  input  logic [DW-1:0]   xo,
  output logic            busy
);

  localparam int unsigned CW = PIF_ARB_CNT_W;
  localparam logic [CW-1:0] LAT = CW'(RD_LAT);

  pif_arb_state_e  r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_owner;
  logic [1:0]      r_gnt;
  logic [AW-1:0]   r_prwa;
  logic [SUBW-1:0] r_suba;
  logic [DW-1:0]   r_pd;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic            w_sel;
  logic            w_take;
  logic            w_sel_we;

  assign w_take   = (r_state == PIF_ARB_IDLE) && (r0_req || r1_req);
  assign w_sel_we = w_sel ? r1_we : r0_we;

  pif_rr_arb2 u_arb (
    .xclk    (xclk),
    .sys_rst (sys_rst),
    .i_req0  (r0_req),
    .i_req1  (r1_req),
    .i_take  (w_take),
    .o_sel   (w_sel)
  );

  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= PIF_ARB_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    xi_pwr         = 1'b0;
    xi_prdfinished = 1'b0;
    r0_done        = 1'b0;
    r1_done        = 1'b0;
    busy           = (r_state != PIF_ARB_IDLE);
    case (r_state)
      PIF_ARB_IDLE: begin
        if (w_take) w_next = w_sel_we ? PIF_ARB_WR : PIF_ARB_RD_WAIT;
      end
      PIF_ARB_WR: begin
        xi_pwr = 1'b1;
        w_next = PIF_ARB_DONE;
      end
      PIF_ARB_RD_WAIT: begin
        if (r_cnt == LAT) w_next = PIF_ARB_CAPT;
      end
      PIF_ARB_CAPT: begin
        xi_prdfinished = 1'b1;
        w_next         = PIF_ARB_DONE;
      end
      PIF_ARB_DONE: begin
        r0_done = ~r_owner;
        r1_done = r_owner;
        w_next  = PIF_ARB_IDLE;
      end
      default: w_next = PIF_ARB_IDLE;
    endcase
  end

  // Command latch, grant pulse, wait counter and readback capture.
  always_ff @(posedge xclk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt    <= '0;
      r_owner  <= 1'b0;
      r_gnt    <= '0;
      r_prwa   <= '0;
      r_suba   <= '0;
      r_pd     <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_gnt <= '0;
      if (w_take) begin
        r_owner <= w_sel;
        r_gnt   <= w_sel ? 2'b10 : 2'b01;
        r_prwa  <= w_sel ? r1_addr  : r0_addr;
        r_suba  <= w_sel ? r1_suba  : r0_suba;
        r_pd    <= w_sel ? r1_wdata : r0_wdata;
        r_cnt   <= CW'(1);
      end
      if (r_state == PIF_ARB_RD_WAIT && r_cnt != LAT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == PIF_ARB_CAPT) begin
        r_cnt <= '0;
        if (r_owner) r_rdata1 <= xo;
        else         r_rdata0 <= xo;
      end
    end
  end

  assign r0_gnt     = r_gnt[0];
  assign r1_gnt     = r_gnt[1];
  assign r0_rdata   = r_rdata0;
  assign r1_rdata   = r_rdata1;
  assign xi_prwa    = r_prwa;
  assign xi_prdsuba = r_suba;
  assign xi_pd      = r_pd;

endmodule

// File: tb/tb_pif_xbus_arb.sv
module tb_pif_xbus_arb;

  logic       xclk = 1'b0;
  logic       sys_rst;
  logic       r0_req, r1_req, r0_we, r1_we;
  logic [7:0] r0_addr, r1_addr;
  logic [3:0] r0_suba, r1_suba;
  logic [7:0] r0_wdata, r1_wdata;
  logic       r0_gnt, r1_gnt, r0_done, r1_done;
  logic [7:0] r0_rdata, r1_rdata;
  logic       xi_pwr;
  logic [7:0] xi_prwa;
  logic [3:0] xi_prdsuba;
  logic [7:0] xi_pd;
  logic       xi_prdfinished;
  logic [7:0] xo;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 xclk = ~xclk;

  pif_xbus_arb #(.AW(8), .SUBW(4), .DW(8), .RD_LAT(5)) dut (
    .xclk(xclk), .sys_rst(sys_rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_suba(r0_suba), .r1_suba(r1_suba),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .xi_pwr(xi_pwr), .xi_prwa(xi_prwa), .xi_prdsuba(xi_prdsuba), .xi_pd(xi_pd),
    .xi_prdfinished(xi_prdfinished), .xo(xo), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {r0_gnt, r1_gnt, r0_done, r1_done, r0_rdata, r1_rdata, xi_pwr,
              xi_prwa, xi_prdsuba, xi_pd, xi_prdfinished, busy}, 64'd0);
  endtask

  task automatic cyc();
    @(negedge xclk);
  endtask

  function automatic int exp_owner(input int t);
`ifdef PIF_ARB_FIXED_PRIO_EN
    return 0;
`else
    return t % 2;
`endif
  endfunction

  initial begin
    sys_rst = 1'b0;
    r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
    r0_addr = '0; r1_addr = '0; r0_suba = '0; r1_suba = '0;
    r0_wdata = '0; r1_wdata = '0; xo = 8'hEE;
    cyc(); cyc();
    chk_zero("reset_outputs");
    sys_rst = 1'b1;
    cyc();

    // Write: r0 -> addr 0x02, data 0x55
    r0_req = 1; r0_we = 1; r0_addr = 8'h02; r0_wdata = 8'h55;
    cyc();  // C1
    chk("wr_c1_pwr", xi_pwr, 1'b1);
    chk("wr_c1_prwa", xi_prwa, 8'h02);
    chk("wr_c1_pd", xi_pd, 8'h55);
    chk("wr_c1_gnt", {r0_gnt, r1_gnt, r0_done, busy}, 4'b1001);
    cyc();  // C2
    chk("wr_c2_done", {xi_pwr, r0_gnt, r0_done, r1_done, busy}, 5'b00101);
    r0_req = 0;
    cyc();  // C3
    chk("wr_c3_idle", {busy, r0_done, xi_pwr}, 3'b000);
    chk("wr_c3_pd_hold", xi_pd, 8'h55);

    // Read: r1 -> addr 0x00, suba 0x3, xo = 0x63 at C6
    r1_req = 1; r1_we = 0; r1_addr = 8'h00; r1_suba = 4'h3;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("rd_c%0d_bus", k), {xi_prwa, xi_prdsuba, xi_pwr, busy}, {8'h00, 4'h3, 1'b0, 1'b1});
      chk($sformatf("rd_c%0d_strobes", k), {r1_gnt, xi_prdfinished, r1_done, r0_done},
          {(k == 1), (k == 6), 1'b0, 1'b0});
      if (k == 6) xo = 8'h63;
    end
    cyc();  // C7
    chk("rd_c7_done", {r1_done, r0_done, xi_prdfinished}, 3'b100);
    chk("rd_c7_rdata", r1_rdata, 8'h63);
    r1_req = 0; xo = 8'hEE;
    cyc();

    // Contention from reset, then continuous requests
    sys_rst = 1'b0;
    cyc();
    sys_rst = 1'b1;
    r0_req = 1; r0_we = 1; r0_addr = 8'h10; r0_wdata = 8'hA0;
    r1_req = 1; r1_we = 1; r1_addr = 8'h11; r1_wdata = 8'hA1;
    for (int t = 0; t < 4; t++) begin
      int o;
      o = exp_owner(t);
      cyc();
      chk($sformatf("arb%0d_gnt", t), {r0_gnt, r1_gnt, xi_pwr}, {(o == 0), (o == 1), 1'b1});
      chk($sformatf("arb%0d_prwa", t), xi_prwa, 8'h10 + 8'(o));
      cyc();
      chk($sformatf("arb%0d_done", t), {r0_done, r1_done}, {(o == 0), (o == 1)});
      cyc();
      chk($sformatf("arb%0d_gap", t), {busy, r0_gnt, r1_gnt}, 3'b000);
    end
    r0_req = 0; r1_req = 0;
    cyc(); cyc();

    // Reset in the middle of a read
    r0_req = 1; r0_we = 0; r0_addr = 8'h07; r0_suba = 4'h1;
    cyc();  // C1
    chk("rst_c1_gnt", {r0_gnt, xi_prwa}, {1'b1, 8'h07});
    cyc();  // C2
    chk("rst_c2_busy", busy, 1'b1);
    cyc();  // C3
    sys_rst = 1'b0;
    #1;
    chk_zero("rst_async_zero");
    r0_req = 0;
    cyc();
    chk_zero("rst_held_zero");
    sys_rst = 1'b1;
    cyc();
    chk("rst_after_idle", {busy, r0_done, r1_done}, 3'b000);

    // Re-issued read completes normally, r0 then keeps req high
    r0_req = 1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("rr_c%0d", k), {xi_prwa, r0_gnt, xi_prdfinished, r0_done},
          {8'h07, (k == 1), (k == 6), 1'b0});
      if (k == 6) xo = 8'h71;
    end
    cyc();  // C7
    chk("rr_c7_done", {r0_done, r0_rdata}, {1'b1, 8'h71});
    xo = 8'hEE;
    cyc();  // idle gap, req still high
    chk("hold_idle", {busy, r0_gnt, r0_rdata}, {1'b0, 1'b0, 8'h71});
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("hold_c%0d", k), {r0_gnt, r0_done, r0_rdata}, {(k == 1), 1'b0, 8'h71});
      if (k == 6) xo = 8'h5A;
    end
    cyc();
    chk("hold_done", {r0_done, r0_rdata}, {1'b1, 8'h5A});
    r0_req = 0;
    cyc(); cyc();
    chk("final_idle", {busy, r0_gnt, r1_gnt}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
